bitserial_ctrl: RTL and testbench

Control unit that sequences the 8-bit bit-serial logic processor's register/compute datapath from the three active-low pushbuttons. Decodes LoadA/LoadB presses into single-cycle register-load strobes, and runs exactly N shift/compute cycles per Execute press. Holds the result until Execute is released. Sits between the button inputs and the register unit; contains no data path of its own.

---
 rtl/bitserial_ctrl_if.sv | 25 ++
 rtl/bitserial_ctrl.sv | 125 ++++++++++++
 tb/tb_bitserial_ctrl.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/bitserial_ctrl_if.sv
// Button inputs and sequencing outputs of the bit-serial processor control unit.
// The slave side is the controller; the master side drives the buttons.
interface bitserial_ctrl_if #(
   parameter int CW = 3
);
   logic          LoadA;
   logic          LoadB;
   logic          Execute;
   logic          Ld_A;
   logic          Ld_B;
   logic          Shift_En;
   logic          Busy;
   logic          Done;
   logic [CW-1:0] Count;

   modport master (
      output LoadA, LoadB, Execute,
      input  Ld_A, Ld_B, Shift_En, Busy, Done, Count
   );

   modport slave (
      input  LoadA, LoadB, Execute,
      output Ld_A, Ld_B, Shift_En, Busy, Done, Count
   );
endinterface

// File: rtl/bitserial_ctrl.sv
// Control unit for the 8-bit bit-serial processor: load strobes and N-cycle shift runs.
// Optional macro BITSERIAL_CTRL_SYNC_EN adds two-flop input synchronizers.
module bitserial_ctrl #(
   parameter int N  = 8,
   parameter int CW = $clog2(N)
) (
   input  logic            Clk,
   input  logic            Reset,
   bitserial_ctrl_if.slave bus
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SHIFT = 2'd1,
      S_HOLD  = 2'd2
   } state_t;

   localparam logic [CW-1:0] LAST = CW'(N - 1);

   state_t        r_state;
   state_t        w_state_nxt;
   logic [CW-1:0] r_count;
   logic [CW-1:0] w_count_nxt;
   logic          r_ld_a;
   logic          r_ld_b;
   logic          w_ld_a_nxt;
   logic          w_ld_b_nxt;
   logic          r_prev_a;
   logic          r_prev_b;
   logic          w_load_a;
   logic          w_load_b;
   logic          w_exec;

`ifdef BITSERIAL_CTRL_SYNC_EN
   logic [1:0] r_sync_a;
   logic [1:0] r_sync_b;
   logic [1:0] r_sync_e;

   // Two-flop synchronizers, reset to the released level
   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         r_sync_a <= 2'b11;
         r_sync_b <= 2'b11;
         r_sync_e <= 2'b11;
      end else begin
         r_sync_a <= {r_sync_a[0], bus.LoadA};
         r_sync_b <= {r_sync_b[0], bus.LoadB};
         r_sync_e <= {r_sync_e[0], bus.Execute};
      end
   end

   assign w_load_a = r_sync_a[1];
   assign w_load_b = r_sync_b[1];
   assign w_exec   = r_sync_e[1];
`else
   assign w_load_a = bus.LoadA;
   assign w_load_b = bus.LoadB;
   assign w_exec   = bus.Execute;
`endif

   // State, counter, strobes and edge history
   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         r_state  <= S_IDLE;
         r_count  <= {CW{1'b0}};
         r_ld_a   <= 1'b0;
         r_ld_b   <= 1'b0;
         r_prev_a <= 1'b1;
         r_prev_b <= 1'b1;
      end else begin
         r_state  <= w_state_nxt;
         r_count  <= w_count_nxt;
         r_ld_a   <= w_ld_a_nxt;
         r_ld_b   <= w_ld_b_nxt;
         r_prev_a <= w_load_a;
         r_prev_b <= w_load_b;
      end
   end

   // Next-state, count and strobe decode; Execute pre-empts loads in IDLE
   always_comb begin
      w_state_nxt = r_state;
      w_count_nxt = r_count;
      w_ld_a_nxt  = 1'b0;
      w_ld_b_nxt  = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (!w_exec) begin
               w_state_nxt = S_SHIFT;
               w_count_nxt = {CW{1'b0}};
            end else begin
               w_ld_a_nxt = r_prev_a & ~w_load_a;
               w_ld_b_nxt = r_prev_b & ~w_load_b;
            end
         end
         S_SHIFT: begin
            if (r_count == LAST) begin
               w_state_nxt = S_HOLD;
            end else begin
               w_count_nxt = r_count + CW'(1);
            end
         end
         S_HOLD: begin
            if (w_exec) begin
               w_state_nxt = S_IDLE;
               w_count_nxt = {CW{1'b0}};
            end else begin
               w_state_nxt = S_HOLD;
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
            w_count_nxt = {CW{1'b0}};
         end
      endcase
   end

   assign bus.Ld_A     = r_ld_a;
   assign bus.Ld_B     = r_ld_b;
   assign bus.Shift_En = (r_state == S_SHIFT);
   assign bus.Busy     = (r_state != S_IDLE);
   assign bus.Done     = (r_state == S_HOLD);
   assign bus.Count    = r_count;

endmodule

// File: tb/tb_bitserial_ctrl.sv
// Randomized self-checking bench for bitserial_ctrl against a run-age reference model.
module tb_bitserial_ctrl;
   localparam int N  = 8;
   localparam int CW = $clog2(N);
`ifdef BITSERIAL_CTRL_SYNC_EN
   localparam int LAT = 2;
`else
   localparam int LAT = 0;
`endif

   logic Clk = 1'b0;
   logic Reset;
   always #5 Clk = ~Clk;

   bitserial_ctrl_if #(.CW(CW)) bus ();
   bitserial_ctrl #(.N(N), .CW(CW)) dut (.Clk(Clk), .Reset(Reset), .bus(bus));

   int checks = 0;
   int errors = 0;

   // Reference model: a run is "active" with an age counting cycles since it began
   bit   m_run;
   int   m_age;
   bit   m_lda, m_ldb;
   bit   m_pa, m_pb;
   bit [1:0] m_da, m_db, m_de;

   wire [CW+4:0] obs = {bus.Ld_A, bus.Ld_B, bus.Shift_En, bus.Busy, bus.Done, bus.Count};

   task automatic model_reset();
      m_run = 1'b0; m_age = 0; m_lda = 1'b0; m_ldb = 1'b0;
      m_pa = 1'b1; m_pb = 1'b1;
      m_da = 2'b11; m_db = 2'b11; m_de = 2'b11;
   endtask

   task automatic model_step(input bit a, input bit b, input bit e);
      bit sa, sb, se;
      if (LAT == 2) begin
         sa = m_da[1]; sb = m_db[1]; se = m_de[1];
         m_da = {m_da[0], a}; m_db = {m_db[0], b}; m_de = {m_de[0], e};
      end else begin
         sa = a; sb = b; se = e;
      end
      m_lda = !m_run && se && m_pa && !sa;
      m_ldb = !m_run && se && m_pb && !sb;
      if (!m_run) begin
         if (!se) begin m_run = 1'b1; m_age = 0; end
      end else if (m_age >= N && se) begin
         m_run = 1'b0; m_age = 0;
      end else if (m_age < N) begin
         m_age++;
      end
      m_pa = sa; m_pb = sb;
   endtask

   function automatic logic [CW+4:0] exp_vec();
      logic [CW-1:0] c;
      c = m_run ? CW'((m_age < N) ? m_age : N - 1) : CW'(0);
      return {m_lda, m_ldb, (m_run && m_age < N), m_run, (m_run && m_age == N), c};
   endfunction

   task automatic tick();
      @(posedge Clk);
      model_step(bus.LoadA, bus.LoadB, bus.Execute);
      #1;
   endtask

   task automatic test_reset();
      Reset = 1'b0;
      bus.LoadA = 1'b1; bus.LoadB = 1'b0; bus.Execute = 1'b1;
      model_reset();
      #12;
      checks++;
      if (obs !== '0) begin
         errors++; $display("FAIL reset_state got=%b exp=%b", obs, {(CW+5){1'b0}});
      end
      @(negedge Clk); Reset = 1'b1;
      for (int i = 0; i < 3 + LAT; i++) begin
         tick();
         checks++;
         if (obs !== exp_vec()) begin
            errors++; $display("FAIL held_at_reset got=%b exp=%b", obs, exp_vec());
         end
      end
      bus.LoadB = 1'b1;
      for (int i = 0; i < 3; i++) tick();
   endtask

   task automatic test_loads();
      int na, nb;
      na = 0; nb = 0;
      bus.LoadA = 1'b0;
      for (int i = 0; i < 3 + LAT; i++) begin
         tick();
         if (i >= 3) bus.LoadA = 1'b1;
         na += int'(bus.Ld_A); nb += int'(bus.Ld_B);
         checks++;
         if (obs !== exp_vec()) begin
            errors++; $display("FAIL load_a_model got=%b exp=%b", obs, exp_vec());
         end
      end
      bus.LoadA = 1'b1;
      for (int i = 0; i < 3; i++) tick();
      checks++;
      if (na !== 1 || nb !== 0) begin
         errors++; $display("FAIL load_a_pulses got=%0d/%0d exp=1/0", na, nb);
      end
      na = 0; nb = 0;
      bus.LoadB = 1'b0;
      for (int i = 0; i < 3 + LAT; i++) begin
         tick();
         if (i >= 3) bus.LoadB = 1'b1;
         na += int'(bus.Ld_A); nb += int'(bus.Ld_B);
      end
      bus.LoadB = 1'b1;
      for (int i = 0; i < 3; i++) tick();
      checks++;
      if (na !== 0 || nb !== 1) begin
         errors++; $display("FAIL load_b_pulses got=%0d/%0d exp=0/1", na, nb);
      end
   endtask

   task automatic test_long_execute();
      int ns, nbusy, ndone, idx;
      ns = 0; nbusy = 0; ndone = 0; idx = 0;
      bus.Execute = 1'b0;
      for (int i = 0; i < 20; i++) begin
         tick();
         checks++;
         if (obs !== exp_vec()) begin
            errors++; $display("FAIL long_model got=%b exp=%b", obs, exp_vec());
         end
         if (bus.Shift_En) begin
            checks++;
            if (bus.Count !== CW'(idx)) begin
               errors++; $display("FAIL long_count got=%0d exp=%0d", bus.Count, idx);
            end
            idx++; ns++;
         end
         nbusy += int'(bus.Busy); ndone += int'(bus.Done);
      end
      checks++;
      if (ns !== N || nbusy !== 20 - LAT || ndone !== 20 - LAT - N) begin
         errors++;
         $display("FAIL long_totals got=%0d/%0d/%0d exp=%0d/%0d/%0d",
                  ns, nbusy, ndone, N, 20 - LAT, 20 - LAT - N);
      end
      bus.Execute = 1'b1;
      for (int i = 0; i < LAT + 1; i++) tick();
      checks++;
      if (bus.Busy !== 1'b0 || bus.Count !== CW'(0)) begin
         errors++; $display("FAIL long_release got=%b/%0d exp=0/0", bus.Busy, bus.Count);
      end
      for (int i = 0; i < 3; i++) tick();
   endtask

   task automatic test_short_execute();
      int ns, nbusy;
      ns = 0; nbusy = 0;
      bus.Execute = 1'b0;
      for (int i = 0; i < 16; i++) begin
         tick();
         if (i == 1) bus.Execute = 1'b1;
         ns += int'(bus.Shift_En); nbusy += int'(bus.Busy);
         checks++;
         if (obs !== exp_vec()) begin
            errors++; $display("FAIL short_model got=%b exp=%b", obs, exp_vec());
         end
      end
      checks++;
      if (ns !== N || nbusy !== N + 1) begin
         errors++; $display("FAIL short_totals got=%0d/%0d exp=%0d/%0d", ns, nbusy, N, N + 1);
      end
   endtask

   task automatic test_collision();
      int na, nbusy;
      na = 0; nbusy = 0;
      bus.LoadA = 1'b0; bus.Execute = 1'b0;
      for (int i = 0; i < 16; i++) begin
         tick();
         if (i == 1) bus.Execute = 1'b1;
         na += int'(bus.Ld_A); nbusy += int'(bus.Busy);
         checks++;
         if (obs !== exp_vec()) begin
            errors++; $display("FAIL collide_model got=%b exp=%b", obs, exp_vec());
         end
      end
      checks++;
      if (na !== 0 || nbusy !== N + 1) begin
         errors++; $display("FAIL collide_totals got=%0d/%0d exp=0/%0d", na, nbusy, N + 1);
      end
      bus.LoadA = 1'b1;
      for (int i = 0; i < 3; i++) tick();
   endtask

   task automatic test_reset_mid_run();
      bit found;
      int ns;
      found = 1'b0; ns = 0;
      bus.Execute = 1'b0;
      for (int i = 0; i < 30 && !found; i++) begin
         tick();
         if (bus.Shift_En && bus.Count == CW'(4)) found = 1'b1;
      end
      checks++;
      if (!found) begin
         errors++; $display("FAIL midrun_reach got=timeout exp=count4");
      end
      #2 Reset = 1'b0; bus.Execute = 1'b1;
      model_reset();
      #1;
      checks++;
      if (obs !== '0) begin
         errors++; $display("FAIL midrun_reset got=%b exp=%b", obs, {(CW+5){1'b0}});
      end
      @(negedge Clk); Reset = 1'b1;
      tick();
      bus.Execute = 1'b0;
      for (int i = 0; i < 14; i++) begin
         tick();
         ns += int'(bus.Shift_En);
         checks++;
         if (obs !== exp_vec()) begin
            errors++; $display("FAIL midrun_rerun got=%b exp=%b", obs, exp_vec());
         end
      end
      checks++;
      if (ns !== N) begin
         errors++; $display("FAIL midrun_shifts got=%0d exp=%0d", ns, N);
      end
      bus.Execute = 1'b1;
      for (int i = 0; i < 4; i++) tick();
   endtask

   task automatic test_random();
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(3) == 0) bus.LoadA = ~bus.LoadA;
         if ($urandom_range(3) == 0) bus.LoadB = ~bus.LoadB;
         if ($urandom_range(5) == 0) bus.Execute = ~bus.Execute;
         tick();
         checks++;
         if (obs !== exp_vec()) begin
            errors++; $display("FAIL random_model cycle=%0d got=%b exp=%b", i, obs, exp_vec());
         end
      end
   endtask

   initial begin
      test_reset();
      test_loads();
      test_long_execute();
      test_short_execute();
      test_collision();
      test_reset_mid_run();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
